game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/game_ctrl.sv
// Tic-tac-toe referee: tracks both players' boards, validates moves, and
// reports win/draw one cycle after each accepted move.
module game_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic [9:1] board_p1,
  output logic [9:1] board_p2,
  output logic       turn,
  output logic       illegal,
  output logic       p1_win,
  output logic       p2_win,
  output logic       draw,
  output logic       game_over,
  output logic [3:0] move_count
);

  // state    | meaning
  // IDLE     | after reset, waiting for start
  // P1_TURN  | waiting for a legal player-1 move
  // P1_CHECK | scoring player 1's board after its move
  // P2_TURN  | waiting for a legal player-2 move
  // P2_CHECK | scoring player 2's board after its move
  // DONE     | result held until start
  typedef enum logic [2:0] {IDLE, P1_TURN, P1_CHECK, P2_TURN, P2_CHECK, DONE} state_t;

  state_t     state_q, state_d;
  logic [9:1] board_p1_q, board_p1_d, board_p2_q, board_p2_d;
  logic [3:0] move_count_q, move_count_d;
  logic       turn_q, turn_d, illegal_q, illegal_d;
  logic       p1_win_q, p1_win_d, p2_win_q, p2_win_d;
  logic       draw_q, draw_d, game_over_q, game_over_d;

  logic       in_turn, pos_ok, legal, p1_line, p2_line, board_full;
  logic [9:1] cell_mask;

  function automatic logic has_line(input logic [9:1] b);
    return (b[1] & b[2] & b[3]) | (b[4] & b[5] & b[6]) | (b[7] & b[8] & b[9]) |
           (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) | (b[3] & b[6] & b[9]) |
           (b[1] & b[5] & b[9]) | (b[3] & b[5] & b[7]);
  endfunction

  assign in_turn    = (state_q == P1_TURN) || (state_q == P2_TURN);
  assign pos_ok     = (move_pos >= 4'd1) && (move_pos <= 4'd9);
  assign cell_mask  = pos_ok ? (9'b1 << (move_pos - 4'd1)) : '0;
  assign legal      = in_turn && move_valid && pos_ok &&
                      (((board_p1_q | board_p2_q) & cell_mask) == '0);
  assign p1_line    = has_line(board_p1_q);
  assign p2_line    = has_line(board_p2_q);
  assign board_full = (move_count_q == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = P1_TURN;
    end else begin
      unique case (state_q)
        P1_TURN:  if (legal) state_d = P1_CHECK;
        P2_TURN:  if (legal) state_d = P2_CHECK;
        P1_CHECK: state_d = (p1_line || board_full) ? DONE : P2_TURN;
        P2_CHECK: state_d = (p2_line || board_full) ? DONE : P1_TURN;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    board_p1_d   = board_p1_q;
    board_p2_d   = board_p2_q;
    move_count_d = move_count_q;
    illegal_d    = 1'b0;
    p1_win_d     = p1_win_q;
    p2_win_d     = p2_win_q;
    draw_d       = draw_q;
    game_over_d  = game_over_q;
    if (start) begin
      board_p1_d   = '0;
      board_p2_d   = '0;
      move_count_d = '0;
      p1_win_d     = 1'b0;
      p2_win_d     = 1'b0;
      draw_d       = 1'b0;
      game_over_d  = 1'b0;
    end else if (in_turn && move_valid) begin
      if (legal) begin
        if (state_q == P1_TURN) board_p1_d = board_p1_q | cell_mask;
        else                    board_p2_d = board_p2_q | cell_mask;
        move_count_d = move_count_q + 4'd1;
      end else begin
        illegal_d = 1'b1;
      end
    end else if (state_q == P1_CHECK || state_q == P2_CHECK) begin
      // A completed line wins even when the board is also full.
      if (state_q == P1_CHECK && p1_line) begin
        p1_win_d    = 1'b1;
        game_over_d = 1'b1;
      end else if (state_q == P2_CHECK && p2_line) begin
        p2_win_d    = 1'b1;
        game_over_d = 1'b1;
      end else if (board_full) begin
        draw_d      = 1'b1;
        game_over_d = 1'b1;
      end
    end
    unique case (state_d)
      P2_TURN, P2_CHECK: turn_d = 1'b1;
      DONE:              turn_d = turn_q;
      default:           turn_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_p1_q   <= '0;
      board_p2_q   <= '0;
      move_count_q <= '0;
      turn_q       <= 1'b0;
      illegal_q    <= 1'b0;
      p1_win_q     <= 1'b0;
      p2_win_q     <= 1'b0;
      draw_q       <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      board_p1_q   <= board_p1_d;
      board_p2_q   <= board_p2_d;
      move_count_q <= move_count_d;
      turn_q       <= turn_d;
      illegal_q    <= illegal_d;
      p1_win_q     <= p1_win_d;
      p2_win_q     <= p2_win_d;
      draw_q       <= draw_d;
      game_over_q  <= game_over_d;
    end
  end

  assign move_ready = in_turn;
  assign board_p1   = board_p1_q;
  assign board_p2   = board_p2_q;
  assign move_count = move_count_q;
  assign turn       = turn_q;
  assign illegal    = illegal_q;
  assign p1_win     = p1_win_q;
  assign p2_win     = p2_win_q;
  assign draw       = draw_q;
  assign game_over  = game_over_q;

endmodule
